// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: RUN/PAUSE/ADJUST sequencing, one-second time base
// and field blanking. All outputs are registered from next-state values.
module stopwatch_ctrl #(
  parameter int TICKS_PER_SEC = 100,
  parameter int SUB_W         = $clog2(TICKS_PER_SEC)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_base,
  input  logic       tick_adj,
  input  logic       tick_blink,
  input  logic       pause_pulse,
  input  logic       sel,
  input  logic       adj,
  output logic       clr,
  output logic       sec_inc,
  output logic       min_adj_inc,
  output logic       sec_adj_inc,
  output logic       blank_min,
  output logic       blank_sec,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    PAUSE  = 2'b01,
    ADJUST = 2'b10
  } state_t;

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

  state_t           st, stNext;
  logic             savedRun, savedRunNext;
  logic [SUB_W-1:0] subCnt, subCntNext;
  logic             blinkPh, blinkNext;
  logic             secIncNext, minAdjNext, secAdjNext;
  logic             blankMinNext, blankSecNext;

  always_comb begin
    stNext       = st;
    savedRunNext = savedRun;
    subCntNext   = subCnt;
    secIncNext   = 1'b0;
    minAdjNext   = 1'b0;
    secAdjNext   = 1'b0;
    blinkNext    = blinkPh ^ tick_blink;
    blankMinNext = 1'b0;
    blankSecNext = 1'b0;

    // Pulse decisions use the current state; the transition only affects later cycles.
    case (st)
      RUN: begin
        if (tick_base) begin
          if (subCnt == SUB_LAST) begin
            subCntNext = '0;
            secIncNext = 1'b1;
          end else begin
            subCntNext = subCnt + SUB_W'(1);
          end
        end
        if (adj) begin
          stNext       = ADJUST;
          savedRunNext = 1'b1;
        end else if (pause_pulse) begin
          stNext = PAUSE;
        end
      end
      PAUSE: begin
        if (adj) begin
          stNext       = ADJUST;
          savedRunNext = 1'b0;
        end else if (pause_pulse) begin
          stNext = RUN;
        end
      end
      ADJUST: begin
        if (tick_adj) begin
          minAdjNext = ~sel;
          secAdjNext = sel;
        end
        if (!adj) begin
          stNext = savedRun ? RUN : PAUSE;
        end
      end
      default: stNext = RUN;
    endcase

    // Blanking follows the state and blink phase that take effect next cycle.
    case (stNext)
      PAUSE: begin
        blankMinNext = blinkNext;
        blankSecNext = blinkNext;
      end
      ADJUST: begin
        blankMinNext = blinkNext & ~sel;
        blankSecNext = blinkNext & sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= RUN;
      savedRun    <= 1'b1;
      subCnt      <= '0;
      blinkPh     <= 1'b0;
      clr         <= 1'b1;
      sec_inc     <= 1'b0;
      min_adj_inc <= 1'b0;
      sec_adj_inc <= 1'b0;
      blank_min   <= 1'b0;
      blank_sec   <= 1'b0;
      running     <= 1'b1;
      state       <= RUN;
    end else begin
      st          <= stNext;
      savedRun    <= savedRunNext;
      subCnt      <= subCntNext;
      blinkPh     <= blinkNext;
      clr         <= 1'b0;
      sec_inc     <= secIncNext;
      min_adj_inc <= minAdjNext;
      sec_adj_inc <= secAdjNext;
      blank_min   <= blankMinNext;
      blank_sec   <= blankSecNext;
      running     <= (stNext == RUN);
      state       <= stNext;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICKS_PER_SEC=4: expected pulses are
// queued with the clock edge they must appear on; a monitor pops and compares.
module tb_stopwatch_ctrl;

  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] SEC  = 3'b001;
  localparam logic [2:0] MADJ = 3'b010;
  localparam logic [2:0] SADJ = 3'b100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_base = 1'b0, tick_adj = 1'b0, tick_blink = 1'b0, pause_pulse = 1'b0;
  logic       sel = 1'b0, adj = 1'b0;
  logic       clr, sec_inc, min_adj_inc, sec_adj_inc, blank_min, blank_sec, running;
  logic [1:0] state;

  typedef struct {
    logic [2:0] kind;
    int         edgeN;
  } exp_t;

  exp_t q[$];
  int   edgeCnt = 0;
  int   checks = 0;
  int   errors = 0;
  logic expBlink = 1'b0;

  stopwatch_ctrl #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .reset(reset), .tick_base(tick_base), .tick_adj(tick_adj),
    .tick_blink(tick_blink), .pause_pulse(pause_pulse), .sel(sel), .adj(adj),
    .clr(clr), .sec_inc(sec_inc), .min_adj_inc(min_adj_inc), .sec_adj_inc(sec_adj_inc),
    .blank_min(blank_min), .blank_sec(blank_sec), .running(running), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Monitor: every pulse must match the head of the queue in kind and edge.
  always @(posedge clk) begin
    logic [2:0] obs;
    exp_t       e;
    #2;
    obs = {sec_adj_inc, min_adj_inc, sec_inc};
    while (q.size() > 0 && q[0].edgeN < edgeCnt) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pulse edge %0d: got none, expected kind %b", e.edgeN, e.kind);
    end
    if (obs !== NONE) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse edge %0d: got %b, expected none", edgeCnt, obs);
      end else begin
        e = q.pop_front();
        if (e.kind !== obs || e.edgeN != edgeCnt) begin
          errors++;
          $display("FAIL pulse edge %0d kind %b, expected edge %0d kind %b",
                   edgeCnt, obs, e.edgeN, e.kind);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // One clock with the given one-cycle enables; expK is the pulse that edge must produce.
  task automatic drive(input logic tb_, input logic ta_, input logic bl_, input logic pp_,
                       input logic [2:0] expK);
    exp_t e;
    if (expK != NONE) begin
      e.kind  = expK;
      e.edgeN = edgeCnt + 1;
      q.push_back(e);
    end
    if (bl_) expBlink = ~expBlink;
    tick_base   = tb_;
    tick_adj    = ta_;
    tick_blink  = bl_;
    pause_pulse = pp_;
    @(posedge clk);
    #1;
    tick_base   = 1'b0;
    tick_adj    = 1'b0;
    tick_blink  = 1'b0;
    pause_pulse = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, NONE);
  endtask

  task automatic tick3(input logic [2:0] expK);
    drive(1'b1, 1'b0, 1'b0, 1'b0, expK);
    idle(2);
  endtask

  task automatic chkBlank(input string nm, input logic bm, input logic bs);
    chk({nm, "_blank_min"}, {1'b0, blank_min}, {1'b0, bm});
    chk({nm, "_blank_sec"}, {1'b0, blank_sec}, {1'b0, bs});
  endtask

  initial begin
    // Reset then run
    idle(2);
    chk("reset_clr", {1'b0, clr}, 2'd1);
    chk("reset_state", state, 2'b00);
    chk("reset_running", {1'b0, running}, 2'd1);
    chkBlank("reset", 1'b0, 1'b0);
    reset = 1'b0;
    idle(1);
    chk("post_reset_clr", {1'b0, clr}, 2'd0);
    for (int i = 1; i <= 12; i++) tick3((i % 4 == 0) ? SEC : NONE);
    chk("run_state", state, 2'b00);
    chkBlank("run", 1'b0, 1'b0);

    // Pause preserves the fraction
    tick3(NONE);
    tick3(NONE);
    drive(1'b0, 1'b0, 1'b0, 1'b1, NONE);
    chk("pause_state", state, 2'b01);
    chk("pause_running", {1'b0, running}, 2'd0);
    chkBlank("pause_ph0", 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, NONE);
    chkBlank("pause_ph1", 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) tick3(NONE);
    drive(1'b0, 1'b0, 1'b0, 1'b1, NONE);
    chk("resume_state", state, 2'b00);
    chkBlank("resume", 1'b0, 1'b0);
    tick3(NONE);
    tick3(SEC);

    // Adjust from RUN; tick_adj on the entry cycle yields nothing
    adj = 1'b1;
    sel = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, NONE);
    chk("adj_state", state, 2'b10);
    chk("adj_running", {1'b0, running}, 2'd0);
    chkBlank("adj_min_ph1", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, MADJ);
      idle(1);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, NONE);
    chkBlank("adj_min_ph0", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick3(NONE);
    sel = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, NONE);
    chkBlank("adj_sec_ph1", 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, SADJ);
      idle(1);
    end
    adj = 1'b0;
    sel = 1'b0;
    idle(1);
    chk("adj_exit_run", state, 2'b00);
    chkBlank("adj_exit", 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) tick3((i == 4) ? SEC : NONE);

    // Adjust from PAUSE; pause_pulse ignored inside ADJUST
    drive(1'b0, 1'b0, 1'b0, 1'b1, NONE);
    chk("p_pause", state, 2'b01);
    adj = 1'b1;
    idle(1);
    chk("p_adj", state, 2'b10);
    drive(1'b0, 1'b0, 1'b0, 1'b1, NONE);
    chk("p_adj_ignore_pause", state, 2'b10);
    adj = 1'b0;
    idle(1);
    chk("p_adj_exit_pause", state, 2'b01);
    chkBlank("p_adj_exit", 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, NONE);
    chk("p_resume", state, 2'b00);

    // Simultaneous rollover with pause, then rollover with adj rising
    for (int i = 0; i < 3; i++) tick3(NONE);
    drive(1'b1, 1'b0, 1'b0, 1'b1, SEC);
    chk("sim_pause_state", state, 2'b01);
    drive(1'b0, 1'b0, 1'b0, 1'b1, NONE);
    for (int i = 0; i < 3; i++) tick3(NONE);
    adj = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, SEC);
    chk("sim_adj_state", state, 2'b10);
    adj = 1'b0;
    idle(1);
    chk("sim_adj_exit", state, 2'b00);

    // Reset mid-ADJUST with a partial second pending
    for (int i = 0; i < 3; i++) tick3(NONE);
    adj = 1'b1;
    idle(1);
    chk("mid_adj_state", state, 2'b10);
    reset = 1'b1;
    adj = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, NONE);
    chk("mid_reset_state", state, 2'b00);
    chk("mid_reset_running", {1'b0, running}, 2'd1);
    chk("mid_reset_clr", {1'b0, clr}, 2'd1);
    chkBlank("mid_reset", 1'b0, 1'b0);
    reset = 1'b0;
    expBlink = 1'b0;
    idle(1);
    chk("mid_post_clr", {1'b0, clr}, 2'd0);
    for (int i = 1; i <= 4; i++) tick3((i == 4) ? SEC : NONE);

    idle(3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d pending, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Mode controller and time-base sequencer for the stopwatch datapath. It sits between the debounced user inputs and the minutes/seconds counter and display blocks. It converts a base-rate enable into one-second count pulses, and runs the RUN/PAUSE/ADJUST state machine. It issues all increment, clear and field-blanking controls so that the counter and display carry no mode logic of their own. Everything runs on the single master clock; every rate input is a one-cycle enable, not a derived clock.

## Interface
- TICKS_PER_SEC, 100: `tick_base` pulses per counted second; must be ≥ 2.
- SUB_W, $clog2(TICKS_PER_SEC): width of the sub-second counter.

- clk  input  1  master clock
- reset  input  1  reset, synchronous, active-high
- tick_base  input  1  one-cycle enable at TICKS_PER_SEC Hz
- tick_adj  input  1  one-cycle enable at the adjust rate (2 Hz)
- tick_blink  input  1  one-cycle enable; toggles the blink phase
- pause_pulse  input  1  debounced rising-edge pulse from the pause button
- sel  input  1  debounced level: 0 = minutes field, 1 = seconds field
- adj  input  1  debounced level: 1 = adjust mode
- clr  output  1  counter clear
- sec_inc  output  1  one-cycle pulse: advance the stopwatch by 1 s
- min_adj_inc  output  1  one-cycle pulse: adjust increment of minutes
- sec_adj_inc  output  1  one-cycle pulse: adjust increment of seconds
- blank_min  output  1  display blanks the minutes digits
- blank_sec  output  1  display blanks the seconds digits
- running  output  1  high only in RUN
- state  output  2  00 RUN, 01 PAUSE, 10 ADJUST

## Operation
- **Registers:** `st`, `saved_run` (1 b), `sub_cnt` (SUB_W), `blink_ph` (1 b). All outputs are registered.
- **Reset:**
  - st=RUN, saved_run=1, sub_cnt=0, blink_ph=0.
  - clr=1 on every cycle reset is high; all other outputs are 0, with running=1 and state=00.
  - The first cycle after reset deasserts has clr=0.
- **blink_ph:** toggles on every tick_blink in all states. It is cleared only by reset.
- **RUN:**
  - On tick_base: if sub_cnt==TICKS_PER_SEC-1, set sub_cnt←0 and pulse sec_inc; otherwise sub_cnt+1.
  - blank_min=blank_sec=0.
- **PAUSE:**
  - sub_cnt is frozen, so the fractional second is preserved. No sec_inc.
  - blank_min=blank_sec=blink_ph (whole display blinks).
- **ADJUST:**
  - sub_cnt is frozen. sec_inc and tick_base are ignored.
  - On tick_adj: pulse min_adj_inc if sel=0, else sec_adj_inc.
  - The selected field is blanked with blink_ph; the other field is blanked 0.
  - sel changes take effect on the next tick_adj and blanking cycle.
- **Transitions, in priority order:**
  1. reset.
  2. adj=1 in RUN/PAUSE → ADJUST, with saved_run←(st==RUN).
  3. adj=0 in ADJUST → RUN if saved_run, else PAUSE.
  4. pause_pulse in RUN → PAUSE; pause_pulse in PAUSE → RUN.
- **Ignored inputs:** pause_pulse is ignored in ADJUST, and saved_run is not toggled by it.
- **Simultaneous events:**
  - RUN with a rollover tick_base and pause_pulse in the same cycle: sec_inc is still issued, then st=PAUSE.
  - adj rising with a rollover tick_base in the same cycle: sec_inc is issued, then ADJUST.
  - tick_adj on the entry cycle into ADJUST produces no pulse, because the pulse decision uses the current st.
- **Output exclusivity:** sec_inc, min_adj_inc and sec_adj_inc are mutually exclusive, never high together.
- **Reset mid-operation:** reset in any state clears sub_cnt, so the next second is a full TICKS_PER_SEC ticks. It also discards saved_run.

## Timing
- sec_inc rises in the cycle after the clk edge that samples the rollover tick_base; latency is 1 cycle. It is one cycle wide.
- min_adj_inc and sec_adj_inc: 1 cycle after tick_adj, one cycle wide.
- state, running and blank_* update 1 cycle after the causing input.
- In steady RUN, consecutive sec_inc pulses are exactly TICKS_PER_SEC tick_base pulses apart, regardless of any intervening pauses.
- Pause/resume adds no lost or extra ticks: sub_cnt resumes from its frozen value.

## Test plan
- **Reset then run:** TICKS_PER_SEC=4, reset for 2 cycles, then tick_base every 3 cycles → clr high only during reset; state=00; first sec_inc 1 cycle after the 4th tick_base; then one every 12 cycles.
- **Pause preserves fraction:** 2 tick_base, pause_pulse, 10 tick_base, pause_pulse, 2 tick_base → no sec_inc while paused; sec_inc after the 4th counted tick; blank_min=blank_sec follow blink_ph only in PAUSE.
- **Adjust from RUN:** adj=1, sel=0, three tick_adj, then sel=1, two tick_adj, then adj=0 → exactly 3 min_adj_inc then 2 sec_adj_inc; blank_min blinks then blank_sec blinks; returns to state=00.
- **Adjust from PAUSE:** with pause_pulse asserted while in ADJUST → ignored; the exit returns to state=01.
- **Simultaneous events:** rollover tick_base with pause_pulse in the same cycle → sec_inc=1 and next state=01. Rollover tick_base with adj rising → sec_inc=1, then state=10.
- **Reset mid-ADJUST:** reset during ADJUST with sub_cnt=3 → state=00, running=1, sub_cnt=0, all pulses 0; next sec_inc after 4 full tick_base.
